sdram_burst_writer: RTL and testbench



---
 rtl/sdram_test_pkg.sv | 12 +
 rtl/sdram_burst_writer_if.sv | 12 +
 rtl/sdram_burst_planner.sv | 16 +
 rtl/sdram_burst_writer.sv | 88 ++++++++
 tb/tb_sdram_burst_writer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg: shared widths, FSM states and the 64-bit fill pattern used by the writer and the read-side checker
package sdram_test_pkg;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 64;
  localparam int BURST_W = 8;
  typedef enum logic [1:0] {IDLE, SETUP, BURST, DONE} state_t;
  function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed, input logic [31:0] idx);
    logic [31:0] v;
    v = seed + idx;
    return {v, ~v};
  endfunction
endpackage

// File: rtl/sdram_burst_writer_if.sv
// sdram_burst_writer_if: Avalon-MM burst write bus (address, burstCount, writeData, byteEnable, write, waitRequest)
interface sdram_burst_writer_if;
  import sdram_test_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [BURST_W-1:0] burstCount;
  logic [DATA_W-1:0] writeData;
  logic [7:0] byteEnable;
  logic write;
  logic waitRequest;
  modport master(output address, burstCount, writeData, byteEnable, write, input waitRequest);
  modport slave(input address, burstCount, writeData, byteEnable, write, output waitRequest);
endinterface

// File: rtl/sdram_burst_planner.sv
// sdram_burst_planner: burst length min(remaining, MAX_BURST) and post-burst address (remaining, cur_addr, burst_len -> blen, next_addr)
module sdram_burst_planner
  import sdram_test_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W = 24
) (
  input  logic [CNT_W-1:0]   remaining,
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [BURST_W-1:0] burst_len,
  output logic [BURST_W-1:0] blen,
  output logic [ADDR_W-1:0]  next_addr
);
  assign blen = remaining < CNT_W'(MAX_BURST) ? remaining[BURST_W-1:0] : BURST_W'(MAX_BURST);
  assign next_addr = cur_addr + ADDR_W'(burst_len);
endmodule

// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer: Avalon burst master filling SDRAM with pat(seed, i); clk/rst, start/start_addr/num_words/seed in, av bus, busy/done/words_written out
module sdram_burst_writer
  import sdram_test_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [CNT_W-1:0]     num_words,
  input  logic [31:0]          seed,
  sdram_burst_writer_if.master av,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     words_written
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, next_addr;
  logic [CNT_W-1:0] remaining, idx;
  logic [31:0] seed_q;
  logic [BURST_W-1:0] beat, blen;
  logic accept, last;
  assign accept = av.write && !av.waitRequest;
  assign last = beat == av.burstCount - 1'b1;
  sdram_burst_planner #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_planner (
    .remaining(remaining),
    .cur_addr(cur_addr),
    .burst_len(av.burstCount),
    .blen(blen),
    .next_addr(next_addr)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // write is decoded from the state register so an async reset drops it at once
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = start ? SETUP : IDLE;
      SETUP:   state_nxt = remaining == '0 ? DONE : BURST;
      BURST:   state_nxt = accept && last ? SETUP : BURST;
      default: state_nxt = IDLE;
    endcase
    av.write = state == BURST;
    av.byteEnable = {8{av.write}};
    av.writeData = av.write ? pat(seed_q, 32'(idx)) : '0;
    busy = state == SETUP || state == BURST;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_addr <= '0;
      remaining <= '0;
      idx <= '0;
      seed_q <= '0;
      beat <= '0;
      words_written <= '0;
      av.address <= '0;
      av.burstCount <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          seed_q <= seed;
          cur_addr <= start_addr;
          remaining <= num_words;
          idx <= '0;
          words_written <= '0;
        end
        SETUP: if (remaining != '0) begin
          av.address <= cur_addr;
          av.burstCount <= blen;
          beat <= '0;
        end
        BURST: if (accept) begin
          idx <= idx + 1'b1;
          words_written <= words_written + 1'b1;
          beat <= beat + 1'b1;
          if (last) begin
            cur_addr <= next_addr;
            remaining <= remaining - CNT_W'(av.burstCount);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer: table-driven runs with a beat scoreboard, plus restart, reset and address-wrap sequences
module tb_sdram_burst_writer;
  import sdram_test_pkg::*;
  typedef struct packed {
    logic [28:0] addr;
    logic [7:0]  bc;
    logic [63:0] data;
  } beat_t;
  typedef struct {
    logic [28:0] sa;
    logic [23:0] n;
    logic [31:0] sd;
    int stall;
    int bursts;
  } vec_t;
  logic clk = 0, rst = 1;
  logic start_a = 0, start_b = 0;
  logic [28:0] sa_a = 0, sa_b = 0;
  logic [23:0] n_a = 0, n_b = 0;
  logic [31:0] sd_a = 0, sd_b = 0;
  logic busy_a, done_a, busy_b, done_b;
  logic [23:0] ww_a, ww_b;
  int stall_a = 0;
  int checks = 0, errors = 0;
  int beats_a = 0, bursts_a = 0, wcyc_a = 0, dones_a = 0;
  int b_beats = 0, b_dones = 0;
  bit wprev = 0, stall_prev = 0, bwprev = 0;
  logic [108:0] snap = '0;
  beat_t exp_a[$];
  beat_t e;
  logic [63:0] got_a[$];
  logic [28:0] b_addrs[$];
  vec_t vecs[5];
  sdram_burst_writer_if ia();
  sdram_burst_writer_if ib();
  sdram_burst_writer #(.MAX_BURST(16), .CNT_W(24)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_addr(sa_a), .num_words(n_a), .seed(sd_a),
    .av(ia), .busy(busy_a), .done(done_a), .words_written(ww_a)
  );
  sdram_burst_writer #(.MAX_BURST(8), .CNT_W(24)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_addr(sa_b), .num_words(n_b), .seed(sd_b),
    .av(ib), .busy(busy_b), .done(done_b), .words_written(ww_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  initial begin
    ia.waitRequest = 0;
    ib.waitRequest = 0;
  end
  always @(posedge clk) begin
    #1;
    ia.waitRequest = stall_a != 0 && int'($urandom_range(99)) < stall_a;
  end
  always @(negedge clk) begin
    if (ia.write) begin
      if (stall_prev)
        chk("stall_hold", {ia.address, ia.burstCount, ia.writeData, ia.byteEnable}, snap);
      if (!wprev) bursts_a++;
      wcyc_a++;
      if (!ia.waitRequest) begin
        if (exp_a.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_a.pop_front();
          chk("beat", {ia.address, ia.burstCount, ia.writeData, ia.byteEnable}, {e.addr, e.bc, e.data, 8'hFF});
        end
        got_a.push_back(ia.writeData);
        beats_a++;
      end
    end
    wprev = ia.write;
    stall_prev = ia.write && ia.waitRequest;
    snap = {ia.address, ia.burstCount, ia.writeData, ia.byteEnable};
    if (done_a) dones_a++;
  end
  always @(negedge clk) begin
    if (ib.write && !bwprev) b_addrs.push_back(ib.address);
    if (ib.write && !ib.waitRequest) begin
      chk("b_data", ib.writeData, {sd_b + 32'(b_beats), ~(sd_b + 32'(b_beats))});
      b_beats++;
    end
    bwprev = ib.write;
    if (done_b) b_dones++;
  end
  task automatic push_exp(input logic [28:0] sa, input logic [23:0] n, input logic [31:0] sd);
    beat_t x;
    for (int i = 0; i < int'(n); i++) begin
      int b = i / 16 * 16;
      x.addr = sa + 29'(b);
      x.bc = 8'((int'(n) - b) < 16 ? int'(n) - b : 16);
      x.data = {sd + 32'(i), ~(sd + 32'(i))};
      exp_a.push_back(x);
    end
  endtask
  task automatic run_a(input logic [28:0] sa, input logic [23:0] n, input logic [31:0] sd, input int stall, input bit restart);
    int d0 = dones_a;
    push_exp(sa, n, sd);
    got_a.delete();
    stall_a = stall;
    @(posedge clk); #1;
    start_a = 1; sa_a = sa; n_a = n; sd_a = sd;
    @(posedge clk); #1;
    start_a = 0;
    @(negedge clk);
    chk("busy_after_start", busy_a, 1);
    if (restart) begin
      repeat (8) @(posedge clk);
      #1 start_a = 1; sa_a = 29'h5; n_a = 24'd3; sd_a = 32'hDEAD;
      @(posedge clk); #1 start_a = 0;
    end
    for (int c = 0; c < 4000 && dones_a == d0; c++) @(negedge clk);
    chk("done_seen", dones_a != d0, 1);
    repeat (3) @(negedge clk);
    stall_a = 0;
  endtask
  initial begin
    int b0, u0, w0, d0;
    vecs[0] = '{29'h100, 24'd32, 32'h0, 0, 2};
    vecs[1] = '{29'h200, 24'd20, 32'h12345678, 0, 2};
    vecs[2] = '{29'h300, 24'd40, 32'hFFFFFFF0, 50, 3};
    vecs[3] = '{29'h1FFFFFF8, 24'd16, 32'h7, 0, 1};
    vecs[4] = '{29'h40, 24'd0, 32'h0, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ia.write, ia.address, ia.burstCount, ia.writeData, ia.byteEnable, busy_a, done_a, ww_a},
        '0);
    @(posedge clk); #1 rst = 0;
    for (int v = 0; v < 5; v++) begin
      b0 = beats_a; u0 = bursts_a; w0 = wcyc_a; d0 = dones_a;
      run_a(vecs[v].sa, vecs[v].n, vecs[v].sd, vecs[v].stall, 0);
      chk($sformatf("v%0d_beats", v), beats_a - b0, int'(vecs[v].n));
      chk($sformatf("v%0d_bursts", v), bursts_a - u0, vecs[v].bursts);
      if (vecs[v].stall == 0) chk($sformatf("v%0d_write_cycles", v), wcyc_a - w0, int'(vecs[v].n));
      chk($sformatf("v%0d_words_written", v), ww_a, vecs[v].n);
      chk($sformatf("v%0d_done_pulses", v), dones_a - d0, 1);
      chk($sformatf("v%0d_queue_empty", v), exp_a.size(), 0);
      chk($sformatf("v%0d_idle", v), {busy_a, ia.write}, 0);
      if (v == 0) begin
        chk("v0_first_data", got_a[0], 64'h00000000_FFFFFFFF);
        chk("v0_last_data", got_a[31], 64'h0000001F_FFFFFFE0);
      end
    end
    b0 = beats_a; u0 = bursts_a;
    run_a(29'h1000, 24'd64, 32'hA5A50000, 0, 1);
    chk("restart_beats", beats_a - b0, 64);
    chk("restart_bursts", bursts_a - u0, 4);
    chk("restart_words_written", ww_a, 24'd64);
    chk("restart_queue_empty", exp_a.size(), 0);
    b0 = beats_a; d0 = dones_a;
    push_exp(29'h80, 24'd32, 32'h55);
    @(posedge clk); #1;
    start_a = 1; sa_a = 29'h80; n_a = 24'd32; sd_a = 32'h55;
    @(posedge clk); #1 start_a = 0;
    for (int c = 0; c < 200 && beats_a - b0 < 5; c++) @(negedge clk);
    chk("rst_reached_beat5", beats_a - b0 >= 5, 1);
    @(posedge clk); #1 rst = 1;
    #1 chk("rst_mid_write", ia.write, 0);
    chk("rst_mid_busy", busy_a, 0);
    exp_a.delete();
    @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", dones_a - d0, 0);
    b0 = beats_a;
    run_a(29'h100, 24'd32, 32'h0, 0, 0);
    chk("post_rst_beats", beats_a - b0, 32);
    chk("post_rst_words_written", ww_a, 24'd32);
    chk("post_rst_first_data", got_a[0], 64'h00000000_FFFFFFFF);
    d0 = b_dones;
    @(posedge clk); #1;
    start_b = 1; sa_b = 29'h1FFFFFF8; n_b = 24'd16; sd_b = 32'h9;
    @(posedge clk); #1 start_b = 0;
    for (int c = 0; c < 500 && b_dones == d0; c++) @(negedge clk);
    chk("wrap_done", b_dones - d0, 1);
    chk("wrap_beats", b_beats, 16);
    chk("wrap_bursts", b_addrs.size(), 2);
    if (b_addrs.size() == 2) begin
      chk("wrap_addr0", b_addrs[0], 29'h1FFFFFF8);
      chk("wrap_addr1", b_addrs[1], 29'h0);
    end
    chk("wrap_words_written", ww_b, 24'd16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
